demux2x24s: RTL

//  Registered 1-to-2 word demultiplexer (de-interleaver): the receive-side counterpart of the 2x24 select mux.

---
 rtl/demux2x24s.sv | 111 +++++++++++
 1 files changed

// File: rtl/demux2x24s.sv
// Registered 1-to-2 word de-interleaver: re-pairs an alternating ch0/ch1 stream onto parallel
// outputs with a pair strobe, tracks alternation via the sync tag and counts sequence errors.
module demux2x24s #(
  parameter int unsigned Width = 24,
  parameter int unsigned Ecw   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [Width-1:0] d_i,
  input  logic             dv_i,
  input  logic             sync_i,
  output logic [Width-1:0] q0_o,
  output logic [Width-1:0] q1_o,
  output logic             qv_o,
  output logic             lock_o,
  output logic             err_o,
  output logic [Ecw-1:0]   ecnt_o
);

  typedef enum logic [1:0] {StHunt, StExp1, StExp0} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] hold_q, hold_d;
  logic [Width-1:0] q0_q, q0_d;
  logic [Width-1:0] q1_q, q1_d;
  logic             qv_q, qv_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;
  logic [Ecw-1:0]   ecnt_q, ecnt_d;
  logic             accept;

  assign accept = ce_i & dv_i;

  // With ce_i low nothing is accepted, so state holds and both pulses drop.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    qv_d    = 1'b0;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;
    if (accept) begin
      unique case (state_q)
        StHunt: begin
          if (sync_i) begin
            hold_d  = d_i;
            state_d = StExp1;
          end
        end
        StExp1: begin
          if (sync_i) begin
            // A repeated ch0 replaces the older one; alternation stays locked.
            hold_d = d_i;
            err_d  = 1'b1;
          end else begin
            q0_d    = hold_q;
            q1_d    = d_i;
            qv_d    = 1'b1;
            state_d = StExp0;
          end
        end
        StExp0: begin
          if (sync_i) begin
            hold_d  = d_i;
            state_d = StExp1;
          end else begin
            err_d   = 1'b1;
            state_d = StHunt;
          end
        end
        default: state_d = StHunt;
      endcase
    end
    if (err_d && (ecnt_q != {Ecw{1'b1}})) begin
      ecnt_d = ecnt_q + Ecw'(1);
    end
    lock_d = (state_d != StHunt);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StHunt;
      hold_q  <= '0;
      q0_q    <= '0;
      q1_q    <= '0;
      qv_q    <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      qv_q    <= qv_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign q0_o   = q0_q;
  assign q1_o   = q1_q;
  assign qv_o   = qv_q;
  assign err_o  = err_q;
  assign lock_o = lock_q;
  assign ecnt_o = ecnt_q;

endmodule
